// File: rtl/register_file_if.sv
// Register file access bundle: write/read strobes, selects, write data, read data.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 8
);
    logic              EN;
    logic [SEL_W-1:0]  selectW1;
    logic [SEL_W-1:0]  selectR1;
    logic [SEL_W-1:0]  selectR2;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] outA;
    logic [DATA_W-1:0] outB;

    modport master (
        output EN, selectW1, selectR1, selectR2, read, write, addr,
        input  outA, outB
    );

    modport slave (
        input  EN, selectW1, selectR1, selectR2, read, write, addr,
        output outA, outB
    );
endinterface

// File: rtl/register_file.sv
// 1W2R register file with registered read ports and r0 hardwired to zero.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-cycle read/write.
module register_file #(
    parameter int DATA_W   = 32,
    parameter int SEL_W    = 8,
    parameter int NUM_REGS = 256
) (
    input  logic          clk,
    input  logic          rst,
    register_file_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] outa_q, outa_d;
    logic [DATA_W-1:0] outb_q, outb_d;
    logic              we;
    logic              re;

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return 32'(sel) < NUM_REGS;
    endfunction

    assign we = bus.EN && bus.write && (bus.selectW1 != '0)
                && in_range(bus.selectW1);
    assign re = bus.EN && bus.read;

    function automatic logic [DATA_W-1:0] rd(input logic [SEL_W-1:0] sel);
        logic [DATA_W-1:0] v;
        v = '0;
        if (sel != '0 && in_range(sel)) begin
            v = regs_q[sel];
`ifdef REGFILE_BYPASS_EN
            if (we && sel == bus.selectW1) begin
                v = bus.addr;
            end
`endif
        end
        return v;
    endfunction

    always_comb begin
        outa_d = outa_q;
        outb_d = outb_q;
        if (re) begin
            outa_d = rd(bus.selectR1);
            outb_d = rd(bus.selectR2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[bus.selectW1] <= bus.addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outa_q <= '0;
            outb_q <= '0;
        end else begin
            outa_q <= outa_d;
            outb_q <= outb_d;
        end
    end

    assign bus.outA = outa_q;
    assign bus.outB = outb_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (16-entry instance).
// Expected values are hand-computed per step.
module tb_register_file;

    localparam int DW = 32;
    localparam int SW = 8;
    localparam int NR = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    register_file_if #(.DATA_W(DW), .SEL_W(SW)) bus ();

    register_file #(
        .DATA_W(DW),
        .SEL_W(SW),
        .NUM_REGS(NR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic wr,
                         input logic [SW-1:0] w1, input logic [DW-1:0] d,
                         input logic rd, input logic [SW-1:0] r1,
                         input logic [SW-1:0] r2);
        bus.EN       = en;
        bus.write    = wr;
        bus.selectW1 = w1;
        bus.addr     = d;
        bus.read     = rd;
        bus.selectR1 = r1;
        bus.selectR2 = r2;
    endtask

    logic [DW-1:0] byp;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, '0, 1'b0, 8'd0, 8'd0);
        #1 rst = 1'b0;
        #1;
        check("rst_async_A", bus.outA, 32'd0);
        check("rst_async_B", bus.outB, 32'd0);

        // Random activity under reset must not change anything
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'($urandom_range(1, 15)), $urandom, 1'b1,
                  8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            cyc();
            check("rst_hold_A", bus.outA, 32'd0);
        end
        rst = 1'b1;

        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd1, 8'd2);
        cyc();
        check("post_rst_A", bus.outA, 32'd0);
        check("post_rst_B", bus.outB, 32'd0);

        drive(1'b1, 1'b1, 8'd1, 32'd123, 1'b0, 8'd0, 8'd0);
        cyc();
        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd1, 8'd2);
        cyc();
        check("wr1_A", bus.outA, 32'd123);
        check("wr1_B", bus.outB, 32'd0);
        drive(1'b1, 1'b0, 8'd0, '0, 1'b0, 8'd2, 8'd1);
        cyc();
        check("hold_A", bus.outA, 32'd123);
        check("hold_B", bus.outB, 32'd0);

        drive(1'b1, 1'b1, 8'd3, 32'd456, 1'b0, 8'd0, 8'd0);
        cyc();
        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd3, 8'd1);
        cyc();
        check("two_A", bus.outA, 32'd456);
        check("two_B", bus.outB, 32'd123);

        drive(1'b1, 1'b1, 8'd0, 32'd999, 1'b0, 8'd0, 8'd0);
        cyc();
        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd0, 8'd1);
        cyc();
        check("r0_A", bus.outA, 32'd0);
        check("r0_keep_B", bus.outB, 32'd123);
        drive(1'b1, 1'b1, 8'd0, 32'd5, 1'b1, 8'd0, 8'd3);
        cyc();
        check("r0_same_A", bus.outA, 32'd0);
        check("r0_same_B", bus.outB, 32'd456);

        // Disabled: neither the write nor the read may take effect
        drive(1'b0, 1'b1, 8'd5, 32'd77, 1'b1, 8'd5, 8'd1);
        cyc();
        check("en0_A", bus.outA, 32'd0);
        check("en0_B", bus.outB, 32'd456);
        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd5, 8'd1);
        cyc();
        check("en1_A", bus.outA, 32'd0);
        check("en1_B", bus.outB, 32'd123);

`ifdef REGFILE_BYPASS_EN
        byp = 32'hDEADBEEF;
`else
        byp = 32'd0;
`endif
        drive(1'b1, 1'b1, 8'd7, 32'hDEADBEEF, 1'b1, 8'd7, 8'd7);
        cyc();
        check("byp_A", bus.outA, byp);
        check("byp_B", bus.outB, byp);
        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd7, 8'd3);
        cyc();
        check("byp_next_A", bus.outA, 32'hDEADBEEF);
        check("byp_next_B", bus.outB, 32'd456);

        // Out-of-range write/read; 20 aliases to 4 if index is truncated
        drive(1'b1, 1'b1, 8'd20, 32'h55, 1'b1, 8'd20, 8'd7);
        cyc();
        check("oor_rd_A", bus.outA, 32'd0);
        check("oor_rd_B", bus.outB, 32'hDEADBEEF);
        drive(1'b1, 1'b1, 8'd15, 32'hABCD, 1'b1, 8'd4, 8'd20);
        cyc();
        check("oor_alias_A", bus.outA, 32'd0);
        check("oor_alias_B", bus.outB, 32'd0);
        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd15, 8'd1);
        cyc();
        check("last_A", bus.outA, 32'hABCD);
        check("last_B", bus.outB, 32'd123);

        // Mid-cycle async reset wins over a pending write/read
        drive(1'b1, 1'b1, 8'd1, 32'd1, 1'b1, 8'd15, 8'd15);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_A", bus.outA, 32'd0);
        check("mid_rst_B", bus.outB, 32'd0);
        cyc();
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd1, 8'd15);
        cyc();
        check("after_rst_A", bus.outA, 32'd0);
        check("after_rst_B", bus.outB, 32'd0);
        drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 8'd7, 8'd3);
        cyc();
        check("after_rst_r7", bus.outA, 32'd0);
        check("after_rst_r3", bus.outB, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file: one write port and two independent read ports, all on a single clock.
- Register 0 is hardwired to zero.
- Read results are registered onto outA/outB and feed the datapath operand buses (ALU A/B inputs).
- A global enable EN gates every state change except reset.

Parameters:
- DATA_W, 32: width of each register and of the addr/outA/outB buses.
- SEL_W, 8: width of the register select fields.
- NUM_REGS, 256: number of implemented registers, indices 0..NUM_REGS-1. Must be ≤ 2**SEL_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; rst=0 clears all state immediately.
- EN  input  1  global enable; when 0, no write and no output update.
- selectW1  input  SEL_W  write register index.
- selectR1  input  SEL_W  read port A register index.
- selectR2  input  SEL_W  read port B register index.
- read  input  1  read strobe; loads both output registers.
- write  input  1  write strobe.
- addr  input  DATA_W  write data (value stored into selectW1).
- outA  output  DATA_W  registered read data, port A.
- outB  output  DATA_W  registered read data, port B.

Behaviour:
- Reset: on rst falling (asynchronous), every register plus outA and outB become 0. State holds at 0 while rst=0.
- Reset release: normal operation from the first rising clk edge with rst=1.
- Write: at posedge, if rst=1, EN=1, write=1, selectW1≠0 and selectW1<NUM_REGS, then reg[selectW1] ← addr. One-cycle latency.
- Ignored writes: writes to index 0 or to an out-of-range index are silently dropped. reg[0] always reads 0.
- Read: at posedge, if rst=1, EN=1 and read=1, then outA ← reg[selectR1] and outB ← reg[selectR2] simultaneously. Data is valid the cycle after the strobe edge.
- Output hold: when read=0 or EN=0, outA/outB keep their last values. No combinational path from selects to outputs.
- Out-of-range read index returns 0.
- Same index on both read ports: both ports return the same value.
- read and write in the same cycle are both performed.
- Same-cycle read of the register being written: result depends on REGFILE_BYPASS_EN (see Optional Feature).
- Write to 0 with a same-cycle read of 0: outputs 0 regardless of the macro.
- Reset asserted mid-cycle: it overrides any pending write or read on that edge.
- No X propagation: all storage is initialised by reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose select equals an active, legal, non-zero write index in the same cycle loads addr, i.e. the new value (write-first forwarding).
- Undefined: that read port loads the pre-write contents (read-first); the new value is visible on the next read.

Test Plan:
1. Reset: rst=0 for 5 cycles with random inputs, then release. Read R1=1, R2=2 → outA=0, outB=0; outputs are 0 during reset without waiting for a clock edge.
2. Basic write/read: EN=1, write=1, selectW1=1, addr=123 for one cycle. Then read=1, selectR1=1, selectR2=2 → next cycle outA=123, outB=0. Drop read; outputs hold 123/0.
3. Two registers: write reg3=456. Then read selectR1=3, selectR2=1 → outA=456, outB=123.
4. Zero register: write selectW1=0, addr=123. Then read selectR1=0 → outA=0. Reg1 still reads 123.
5. Enable gating: EN=0, write=1, selectW1=5, addr=77, then read=1 selectR1=5 → outA unchanged from its prior value. Then EN=1, read reg5 → 0.
6. Bypass: same cycle write reg7=0xDEADBEEF and read selectR1=7 → outA=0xDEADBEEF with REGFILE_BYPASS_EN, 0 without. Next read of reg7 → 0xDEADBEEF in both builds.
